// File: rtl/keyboard.sv
// -----------------------------------------------------------------------------
// keyboard
//   PS/2 keyboard receiver (scan-code set 2) feeding a ZX Spectrum 8x5 key
//   matrix. Frames are deserialised from the filtered PS/2 lines, prefix bytes
//   (E0 extended, F0 break) are tracked, and mapped keys are pressed/released
//   in the matrix. The ULA port 0xFE read is answered combinationally from the
//   half-row select.
//
// Ports
//   clock  in   1  system clock (cpuClock), single domain
//   reset  in   1  asynchronous, active-low
//   ps2Ck  in   1  raw PS/2 clock from the pad (asynchronous)
//   ps2D   in   1  raw PS/2 data from the pad (asynchronous)
//   row    in   8  half-row select a[15:8], active-low, several may be low
//   col    out  5  key columns, active-low (0 = pressed)
// -----------------------------------------------------------------------------
module keyboard #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 2048
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  input  logic [7:0] row,
  output logic [4:0] col
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity over data plus parity bit: a valid frame XORs to 1.
  function automatic logic odd_parity(input logic [8:0] v);
    return ^v;
  endfunction

  // Scan-code lookup. Result is {hit, row[2:0], col[2:0]}.
  function automatic logic [6:0] key_map(input logic e, input logic [7:0] code);
    logic [6:0] m;
    m = 7'd0;
    if (e) begin
      case (code)
        8'h14:   m = {1'b1, 3'd7, 3'd1};   // right ctrl -> symbol shift
        8'h5A:   m = {1'b1, 3'd6, 3'd0};   // keypad enter -> enter
        default: m = 7'd0;
      endcase
    end else begin
      case (code)
        8'h12, 8'h59: m = {1'b1, 3'd0, 3'd0};  // caps shift (either shift key)
        8'h1A:   m = {1'b1, 3'd0, 3'd1};
        8'h22:   m = {1'b1, 3'd0, 3'd2};
        8'h21:   m = {1'b1, 3'd0, 3'd3};
        8'h2A:   m = {1'b1, 3'd0, 3'd4};
        8'h1C:   m = {1'b1, 3'd1, 3'd0};
        8'h1B:   m = {1'b1, 3'd1, 3'd1};
        8'h23:   m = {1'b1, 3'd1, 3'd2};
        8'h2B:   m = {1'b1, 3'd1, 3'd3};
        8'h34:   m = {1'b1, 3'd1, 3'd4};
        8'h15:   m = {1'b1, 3'd2, 3'd0};
        8'h1D:   m = {1'b1, 3'd2, 3'd1};
        8'h24:   m = {1'b1, 3'd2, 3'd2};
        8'h2D:   m = {1'b1, 3'd2, 3'd3};
        8'h2C:   m = {1'b1, 3'd2, 3'd4};
        8'h16:   m = {1'b1, 3'd3, 3'd0};
        8'h1E:   m = {1'b1, 3'd3, 3'd1};
        8'h26:   m = {1'b1, 3'd3, 3'd2};
        8'h25:   m = {1'b1, 3'd3, 3'd3};
        8'h2E:   m = {1'b1, 3'd3, 3'd4};
        8'h45:   m = {1'b1, 3'd4, 3'd0};
        8'h46:   m = {1'b1, 3'd4, 3'd1};
        8'h3E:   m = {1'b1, 3'd4, 3'd2};
        8'h3D:   m = {1'b1, 3'd4, 3'd3};
        8'h36:   m = {1'b1, 3'd4, 3'd4};
        8'h4D:   m = {1'b1, 3'd5, 3'd0};
        8'h44:   m = {1'b1, 3'd5, 3'd1};
        8'h43:   m = {1'b1, 3'd5, 3'd2};
        8'h3C:   m = {1'b1, 3'd5, 3'd3};
        8'h35:   m = {1'b1, 3'd5, 3'd4};
        8'h5A:   m = {1'b1, 3'd6, 3'd0};
        8'h4B:   m = {1'b1, 3'd6, 3'd1};
        8'h42:   m = {1'b1, 3'd6, 3'd2};
        8'h3B:   m = {1'b1, 3'd6, 3'd3};
        8'h33:   m = {1'b1, 3'd6, 3'd4};
        8'h29:   m = {1'b1, 3'd7, 3'd0};
        8'h14:   m = {1'b1, 3'd7, 3'd1};   // left ctrl -> symbol shift
        8'h3A:   m = {1'b1, 3'd7, 3'd2};
        8'h31:   m = {1'b1, 3'd7, 3'd3};
        8'h32:   m = {1'b1, 3'd7, 3'd4};
        default: m = 7'd0;
      endcase
    end
    return m;
  endfunction

  // Index 0 carries the PS/2 clock, index 1 the PS/2 data.
  logic [1:0]          meta_r;
  logic [1:0]          sync_r;
  logic [1:0]          filt_r;
  logic [1:0][FW-1:0]  fcnt_r;
  logic                ck_prev_r;
  logic                fall_s;
  logic                data_s;

  state_t              state_r;
  state_t              state_nx_s;
  logic [2:0]          bit_cnt_r;
  logic [7:0]          shift_r;
  logic                par_r;
  logic [TW-1:0]       tmo_cnt_r;
  logic                timeout_s;
  logic                start_s;
  logic                shift_en_s;
  logic                par_cap_s;
  logic                stop_s;

  logic                byte_valid_r;
  logic [7:0]          byte_r;
  logic                ext_r;
  logic                brk_r;
  logic [6:0]          map_s;
  logic [7:0][4:0]     matrix_r;
  logic [4:0]          col_s;

  // Two-flop synchronisers for both pad inputs; idle level is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_r <= 2'b11;
      sync_r <= 2'b11;
    end else begin
      meta_r <= {ps2D, ps2Ck};
      sync_r <= meta_r;
    end
  end

  // Stability filter: a new level is accepted only after FILTER samples that
  // all differ from the current filtered level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_r <= 2'b11;
      fcnt_r <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] == filt_r[i]) begin
          fcnt_r[i] <= '0;
        end else if (fcnt_r[i] == FW'(FILTER - 1)) begin
          filt_r[i] <= sync_r[i];
          fcnt_r[i] <= '0;
        end else begin
          fcnt_r[i] <= fcnt_r[i] + FW'(1);
        end
      end
    end
  end

  // Previous filtered clock level for falling-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_prev_r <= 1'b1;
    end else begin
      ck_prev_r <= filt_r[0];
    end
  end

  assign fall_s    = ck_prev_r & ~filt_r[0];
  assign data_s    = filt_r[1];
  // A fall in the same cycle restarts the idle count, so it takes priority.
  assign timeout_s = (state_r != IDLE) && !fall_s && (tmo_cnt_r == TW'(TIMEOUT - 1));

  // Receiver state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Receiver next-state logic.
  always_comb begin
    state_nx_s = state_r;
    if (timeout_s) begin
      state_nx_s = IDLE;
    end else if (fall_s) begin
      case (state_r)
        IDLE:    state_nx_s = data_s ? IDLE : DATA;
        DATA:    state_nx_s = (bit_cnt_r == 3'd7) ? PARITY : DATA;
        PARITY:  state_nx_s = STOP;
        STOP:    state_nx_s = IDLE;
        default: state_nx_s = IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Receiver per-state action strobes.
  always_comb begin
    start_s    = 1'b0;
    shift_en_s = 1'b0;
    par_cap_s  = 1'b0;
    stop_s     = 1'b0;
    if (fall_s) begin
      case (state_r)
        IDLE:    start_s    = ~data_s;
        DATA:    shift_en_s = 1'b1;
        PARITY:  par_cap_s  = 1'b1;
        STOP:    stop_s     = 1'b1;
        default: start_s    = 1'b0;
      endcase
    end else begin
      start_s = 1'b0;
    end
  end

  // Receiver datapath: bit counter, shifter, parity capture, byte strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      par_r        <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_r       <= 8'h00;
    end else begin
      byte_valid_r <= 1'b0;
      if (start_s) begin
        bit_cnt_r <= 3'd0;
      end else if (shift_en_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        shift_r   <= {data_s, shift_r[7:1]};   // LSB arrives first
      end else if (par_cap_s) begin
        par_r <= data_s;
      end else if (stop_s) begin
        byte_valid_r <= data_s & odd_parity({par_r, shift_r});
        byte_r       <= shift_r;
      end
    end
  end

  // Mid-frame idle counter; cleared by every clock fall and while idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= '0;
    end else if (fall_s || state_r == IDLE) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end
  end

  assign map_s = key_map(ext_r, byte_r);

  // Decoder: prefix tracking and key matrix update, one byte per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ext_r    <= 1'b0;
      brk_r    <= 1'b0;
      matrix_r <= '1;
    end else if (byte_valid_r) begin
      if (byte_r == 8'hE0) begin
        ext_r <= 1'b1;
      end else if (byte_r == 8'hF0) begin
        brk_r <= 1'b1;
      end else begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
        if (map_s[6]) begin
          // Make drives the bit low, break releases it high.
          matrix_r[map_s[5:3]][map_s[2:0]] <= brk_r;
        end
      end
    end
  end

  // Column read: AND of every selected half-row.
  always_comb begin
    col_s = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      if (!row[r]) begin
        col_s = col_s & matrix_r[r];
      end else begin
        col_s = col_s;
      end
    end
  end

  assign col = col_s;

endmodule

// File: doc/keyboard.md
# keyboard

PS/2 keyboard receiver and ZX Spectrum key-matrix emulator. It deserialises PS/2 scan-code set 2 frames, tracks make and break codes for the 40 Spectrum keys in an 8×5 matrix, and answers the ULA port 0xFE keyboard read. It sits directly upstream of the zx48 CPU data-in mux: `col` becomes bits 4:0 of the byte returned on an `ioFE` read, with `row` driven from `a[15:8]`.

## Interface
Parameters:
- `FILTER`, default 8: consecutive stable samples required before a synchronised `ps2Ck`/`ps2D` level is accepted.
- `TIMEOUT`, default 2048: idle cycles mid-frame before the receiver aborts the frame.

Ports:
- `clock`, in, 1: system clock (cpuClock, 3.5 MHz). One clock domain.
- `reset`, in, 1: asynchronous, active-low.
- `ps2Ck`, in, 1: raw PS/2 clock from the pad, asynchronous.
- `ps2D`, in, 1: raw PS/2 data from the pad, asynchronous.
- `row`, in, 8: half-row select (`a[15:8]`), active-low; several rows may be low at once.
- `col`, out, 5: key columns, active-low. 0 means pressed.

## Operation
- **Input conditioning.** `ps2Ck` and `ps2D` each pass through a 2-FF synchroniser and then a `FILTER`-cycle stability filter. A filtered falling edge of the PS/2 clock produces a 1-cycle `fall` pulse. Data is sampled from filtered `ps2D` on `fall`.
- **Receiver state machine.** States: IDLE, DATA, PARITY, STOP.
  - IDLE: `fall` with data=0 (start bit) moves to DATA with bit count 0. `fall` with data=1 stays in IDLE.
  - DATA: 8 bits are shifted in LSB first. After the 8th bit, move to PARITY.
  - PARITY: capture the bit and move to STOP.
  - STOP: the byte is accepted only if data=1 and the 9 bits (data plus parity) have odd parity. On any error the byte is dropped and the prefix flags are kept. Always return to IDLE.
  - Timeout counter: reset on every `fall`, counts while not IDLE. Reaching `TIMEOUT` forces IDLE and drops the partial byte; prefix flags are kept.
- **Decoder.** Accepted bytes are handled as follows:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte is looked up, then `ext` and `brk` are both cleared. A mapped key clears its matrix bit (make, `brk`=0) or sets it (break, `brk`=1). Unmapped codes have no matrix effect.
- **Non-extended map** (row: bit0..bit4):
  - r0: 12 or 59 (caps shift), 1A, 22, 21, 2A
  - r1: 1C, 1B, 23, 2B, 34
  - r2: 15, 1D, 24, 2D, 2C
  - r3: 16, 1E, 26, 25, 2E
  - r4: 45, 46, 3E, 3D, 36
  - r5: 4D, 44, 43, 3C, 35
  - r6: 5A, 4B, 42, 3B, 33
  - r7: 29, 14 (symbol shift), 3A, 31, 32
- **Extended map** (`ext`=1): only E0 14 (maps to symbol shift) and E0 5A (maps to enter) are mapped. All other extended codes, including E0 12 and E0 59, are unmapped.
- **Matrix read.** `col[i]` is the AND, over every r with `row[r]`=0, of `matrix[r][i]`. With `row`=FF, `col`=1F. This path is combinational from `row`.
- **Reset.** State IDLE, bit count 0, timeout 0, `ext`=`brk`=0, filters at 1 (bus idle high), whole matrix released (all 1). So `col`=1F for any `row`.

## Timing
- Input to `fall` latency: 2 synchroniser cycles plus `FILTER` cycles, plus 1 for edge detect.
- In the cycle `fall` samples the stop bit, the FSM returns to IDLE and registers the byte-valid strobe. The decoder updates the matrix on the next edge, so the change is visible on `col` 2 cycles after the stop-bit `fall`.
- The FSM and decoder accept back-to-back frames. The decoder needs only 1 cycle per byte; no backpressure.
- A `row` change reaches `col` in the same cycle (combinational). The CPU samples `col` during its IO read.
- Reset asserted mid-frame clears everything immediately. After release, the remainder of the frame is seen in IDLE and ignored until the next start bit.
- A make for an already-pressed key is idempotent (auto-repeat). A break for a released key is harmless.

## Test plan
1. **Make then break of A.** Send 1C, then F0 1C, with `row`=FD. Required: `col`=1E after the first frame, `col`=1F after the break. With `row`=FE throughout, `col` stays 1F.
2. **Multi-row select.** Send Z (1A) and P (4D) make codes, then drive `row`=00. Required: `col`=1C. With `row`=DF, `col`=1E. With `row`=FE, `col`=1D.
3. **Parity error.** Send 1C with a wrong parity bit. Required: `col` stays 1F at `row`=FD. A following correct 1C gives `col`=1E.
4. **Timeout.** Send a start bit plus 4 bits, stop clocking for more than `TIMEOUT` cycles, then send a full 2B frame. Required: F pressed (`row`=FD gives `col`=17), no stuck state.
5. **Extended codes.**
   - E0 14 gives `row`=7F → `col`=1D.
   - E0 F0 14 releases it.
   - E0 12 leaves `col` at 1F for every row.
   - E0 5A gives `row`=BF → `col`=1E.
6. **Reset mid-frame.** Hold S (1B) pressed, then assert `reset` during the next frame. Required: `col`=1F immediately, and a subsequent 1B frame gives `row`=FD → `col`=1D.
